// File: rtl/cpu_pkg.sv
// Shared CPU-side types for the vector memory reader: FSM state encoding and lane index width.
package cpu_pkg;

  localparam int unsigned PKG_VECTOR_SIZE  = 6;
  localparam int unsigned LANE_INDEX_WIDTH = $clog2(PKG_VECTOR_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    DONE
  } reader_state_t;

endpackage

// File: rtl/vector_lane_buffer.sv
// Holds one memory word split into lanes and presents the lane picked by the lane index.
module vector_lane_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned VECTOR_SIZE = PKG_VECTOR_SIZE,
  parameter int unsigned LANE_W      = LANE_INDEX_WIDTH
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_load,
  input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] i_word,
  input  logic [LANE_W-1:0]                 i_lane,
  output logic [DATA_WIDTH-1:0]             o_lane_data
);

  logic [DATA_WIDTH-1:0] r_lanes [VECTOR_SIZE];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(VECTOR_SIZE); i++) r_lanes[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < int'(VECTOR_SIZE); i++) r_lanes[i] <= i_word[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_lane_data = r_lanes[i_lane];

endmodule

// File: rtl/vector_mem_reader.sv
// Dumps a run of vector words from data memory as a byte stream over valid/ready.
module vector_mem_reader
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned VECTOR_SIZE   = PKG_VECTOR_SIZE,
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ADDRESS_WIDTH-1:0]          baseAddress,
  input  logic [ADDRESS_WIDTH:0]            wordCount,
  output logic                              memReadEnable,
  output logic [ADDRESS_WIDTH-1:0]          memReadAddress,
  input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] memReadData,
  output logic [DATA_WIDTH-1:0]             byteData,
  output logic                              byteValid,
  input  logic                              byteReady,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned LANE_W = $clog2(VECTOR_SIZE);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VECTOR_SIZE - 1);

  reader_state_t            r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [ADDRESS_WIDTH:0]   r_remaining;
  logic [LANE_W-1:0]        r_lane;
  logic [DATA_WIDTH-1:0]    w_lane_data;
  logic                     w_load;

  assign w_load = (r_state == WAIT);

  vector_lane_buffer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .VECTOR_SIZE (VECTOR_SIZE),
    .LANE_W      (LANE_W)
  ) u_lane_buffer (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_load      (w_load),
    .i_word      (memReadData),
    .i_lane      (r_lane),
    .o_lane_data (w_lane_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_lane      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_addr      <= baseAddress;
            r_remaining <= wordCount;
            r_state     <= (wordCount == '0) ? DONE : READ;
          end
        end
        READ: r_state <= WAIT;
        WAIT: begin
          r_lane  <= '0;
          r_state <= SEND;
        end
        SEND: begin
          if (byteReady) begin
            if (r_lane == LAST_LANE) begin
              r_lane      <= '0;
              r_addr      <= r_addr + ADDRESS_WIDTH'(1);
              r_remaining <= r_remaining - (ADDRESS_WIDTH + 1)'(1);
              // remaining still holds the pre-decrement count here
              r_state     <= (r_remaining != (ADDRESS_WIDTH + 1)'(1)) ? READ : DONE;
            end else begin
              r_lane <= r_lane + LANE_W'(1);
            end
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state and registers; byteReady never reaches them.
  assign memReadEnable  = (r_state == READ);
  assign memReadAddress = (r_state == READ) ? r_addr : '0;
  assign byteValid      = (r_state == SEND);
  assign byteData       = (r_state == SEND) ? w_lane_data : '0;
  assign busy           = (r_state != IDLE);
  assign done           = (r_state == DONE);

endmodule

// File: tb/tb_vector_mem_reader.sv
// Directed bench for vector_mem_reader with a one-cycle-latency memory model.
module tb_vector_mem_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  baseAddress;
  logic [8:0]  wordCount;
  logic        memReadEnable;
  logic [7:0]  memReadAddress;
  logic [47:0] memReadData;
  logic [7:0]  byteData;
  logic        byteValid;
  logic        byteReady;
  logic        busy;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [47:0] mem [256];
  int          rd_count;
  logic [7:0]  rd_addr [4];
  int          done_count;

  vector_mem_reader dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .baseAddress    (baseAddress),
    .wordCount      (wordCount),
    .memReadEnable  (memReadEnable),
    .memReadAddress (memReadAddress),
    .memReadData    (memReadData),
    .byteData       (byteData),
    .byteValid      (byteValid),
    .byteReady      (byteReady),
    .busy           (busy),
    .done           (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (memReadEnable) begin
      memReadData <= mem[memReadAddress];
      if (rd_count < 4) rd_addr[rd_count] <= memReadAddress;
      rd_count <= rd_count + 1;
    end
    if (done) done_count <= done_count + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_count   = 0;
    done_count = 0;
    for (int i = 0; i < 4; i++) rd_addr[i] = 8'h00;
  endtask

  // Drives start for one edge; returns sampling cycle t+1.
  task automatic do_start(input logic [7:0] base, input logic [8:0] count);
    start       = 1'b1;
    baseAddress = base;
    wordCount   = count;
    tick();
    start       = 1'b0;
    baseAddress = 8'h00;
    wordCount   = 9'd0;
  endtask

  function automatic logic [7:0] byte_of(input logic [47:0] w0, input logic [47:0] w1,
                                         input int idx);
    logic [47:0] w;
    w = (idx < 6) ? w0 : w1;
    return w[(idx % 6) * 8 +: 8];
  endfunction

  // Runs from cycle t+1 until the done pulse, checking every valid byte (held or accepted).
  task automatic collect(input string tag, input int n_bytes, input bit bp,
                         input logic [47:0] w0, input logic [47:0] w1, input int inject);
    int got  = 0;
    int k    = 0;
    bit seen = 1'b0;
    while (!seen && k < 80) begin
      byteReady = bp ? (k % 3 == 2) : 1'b1;
      if (k == inject) begin
        start = 1'b1; baseAddress = 8'h40; wordCount = 9'd5;
      end else begin
        start = 1'b0; baseAddress = 8'h00; wordCount = 9'd0;
      end
      if (byteValid) begin
        if (got < n_bytes) check({tag, "_byte"}, byteData, byte_of(w0, w1, got));
        else check({tag, "_extra_byte"}, 1, 0);
        if (byteReady) got++;
      end
      if (done) begin
        seen = 1'b1;
        check({tag, "_count"}, got, n_bytes);
      end else begin
        tick();
        k++;
      end
    end
    start = 1'b0;
    if (!seen) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    baseAddress = 8'h00;
    wordCount   = 9'd0;
    byteReady   = 1'b0;
    memReadData = 48'h0;
    for (int i = 0; i < 256; i++) mem[i] = 48'h0;
    mem[8'h10] = 48'h060504030201;
    mem[8'h40] = 48'hEEEEEEEEEEEE;
    mem[8'hFF] = 48'hA6A5A4A3A2A1;
    mem[8'h00] = 48'hB6B5B4B3B2B1;
    clear_logs();

    tick();
    tick();
    check("rst_mre", memReadEnable, 0);
    check("rst_addr", memReadAddress, 0);
    check("rst_data", byteData, 0);
    check("rst_valid", byteValid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    tick();

    // Single word, exact cycle timing.
    byteReady = 1'b1;
    clear_logs();
    do_start(8'h10, 9'd1);
    check("t1_mre", memReadEnable, 1);
    check("t1_addr", memReadAddress, 8'h10);
    check("t1_busy", busy, 1);
    tick();
    check("t2_mre", memReadEnable, 0);
    check("t2_valid", byteValid, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      check("single_valid", byteValid, 1);
      check("single_byte", byteData, 8'(i + 1));
      tick();
    end
    check("single_done", done, 1);
    check("single_busy_done", busy, 1);
    check("single_valid_off", byteValid, 0);
    tick();
    check("single_done_off", done, 0);
    check("single_busy_off", busy, 0);
    check("single_reads", rd_count, 1);

    // Backpressure: ready pattern 1,0,0 from the first SEND cycle.
    clear_logs();
    do_start(8'h10, 9'd1);
    collect("bp", 6, 1'b1, 48'h060504030201, 48'h0, -1);
    tick();
    check("bp_busy_off", busy, 0);
    check("bp_reads", rd_count, 1);
    check("bp_dones", done_count, 1);

    // Address wrap across 0xFF -> 0x00.
    clear_logs();
    do_start(8'hFF, 9'd2);
    collect("wrap", 12, 1'b0, 48'hA6A5A4A3A2A1, 48'hB6B5B4B3B2B1, -1);
    tick();
    check("wrap_reads", rd_count, 2);
    check("wrap_addr0", rd_addr[0], 8'hFF);
    check("wrap_addr1", rd_addr[1], 8'h00);
    check("wrap_dones", done_count, 1);

    // Zero count goes straight to DONE.
    clear_logs();
    do_start(8'h20, 9'd0);
    check("zero_done", done, 1);
    check("zero_mre", memReadEnable, 0);
    check("zero_valid", byteValid, 0);
    tick();
    check("zero_done_off", done, 0);
    check("zero_busy_off", busy, 0);
    check("zero_reads", rd_count, 0);

    // Start during SEND is ignored.
    clear_logs();
    do_start(8'h10, 9'd1);
    collect("busy_start", 6, 1'b0, 48'h060504030201, 48'h0, 3);
    tick();
    check("busy_start_reads", rd_count, 1);
    check("busy_start_addr", rd_addr[0], 8'h10);
    tick();
    check("busy_start_idle", busy, 0);
    check("busy_start_dones", done_count, 1);

    // Asynchronous reset while lane 3 is on the bus.
    clear_logs();
    byteReady = 1'b1;
    do_start(8'h10, 9'd1);
    tick();
    tick();
    tick();
    tick();
    tick();
    check("mid_lane3", byteData, 8'h04);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", byteValid, 0);
    check("mid_rst_data", byteData, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_mre", memReadEnable, 0);
    check("mid_rst_addr", memReadAddress, 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_idle", busy, 0);
    clear_logs();
    do_start(8'h10, 9'd1);
    collect("post_rst", 6, 1'b0, 48'h060504030201, 48'h0, -1);
    tick();
    check("post_rst_reads", rd_count, 1);
    check("post_rst_dones", done_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_mem_reader.md
# vector_mem_reader

Streams a block of vector words out of the CPU data memory, one byte lane at a time, over a valid/ready byte interface. It is the read-out counterpart of the CPU store path: the pipeline writes DATA_WIDTH*VECTOR_SIZE-bit words, and this block reads them back for a host or display sink once software signals completion. It sits beside the CPU on the data-memory read port and owns that port only while busy.

## Interface
- DATA_WIDTH, 8, width of one lane and of the output byte
- VECTOR_SIZE, 6, lanes per memory word
- ADDRESS_WIDTH, 8, data-memory address width
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE
- baseAddress  input  ADDRESS_WIDTH  first word address, captured on start
- wordCount  input  ADDRESS_WIDTH+1  number of words to dump, captured on start
- memReadEnable  output  1  high for exactly one cycle per word read
- memReadAddress  output  ADDRESS_WIDTH  word address presented to memory
- memReadData  input  DATA_WIDTH*VECTOR_SIZE  read data, valid the cycle after memReadEnable
- byteData  output  DATA_WIDTH  current lane value
- byteValid  output  1  byteData is valid
- byteReady  input  1  sink accepts when byteValid && byteReady at a rising edge
- busy  output  1  high from the cycle after an accepted start until DONE ends
- done  output  1  one-cycle pulse when the dump completes

## Operation
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE: start=1 captures baseAddress into addr and wordCount into remaining. If wordCount==0, the next state is DONE. Otherwise the next state is READ.
- READ: memReadEnable=1 and memReadAddress=addr. The next state is WAIT.
- WAIT: memReadData is latched into the lane register at the edge and lane is set to 0. The next state is SEND.
- SEND: byteValid=1 and byteData=lane[lane], with lane 0 = bits DATA_WIDTH-1:0 sent first.
  - On a handshake, lane increments.
  - On a handshake at lane VECTOR_SIZE-1: addr increments, remaining decrements, and the next state is READ if remaining-1 != 0, otherwise DONE.
- DONE: done=1 for one cycle, then IDLE.
- addr wraps modulo 2^ADDRESS_WIDTH (0xFF+1 -> 0x00). wordCount up to 2^ADDRESS_WIDTH is legal.
- start outside IDLE is ignored. baseAddress and wordCount are don't-care except on an accepted start.
- While byteValid=1 and byteReady=0, byteData is held stable. byteValid never drops before its handshake.
- Reset (asynchronous, at any point, including mid-SEND): state returns to IDLE and all outputs go low/zero. A partially sent word is discarded.

## Timing
- Reset values: memReadEnable=0, memReadAddress=0, byteData=0, byteValid=0, busy=0, done=0.
- start accepted at edge t:
  - cycle t+1: READ, memReadEnable=1.
  - cycle t+2: WAIT.
  - cycle t+3: first byteValid.
- With byteReady held high, each word takes VECTOR_SIZE+2 cycles (8 at default).
- After the last handshake, done is high in the following cycle and busy falls with it. A new start is accepted in the IDLE cycle after that.
- Outputs are registered or decoded directly from state/registers. There is no combinational path from byteReady to any output.

## Structure
- Shared package cpu_pkg holds:
  - reader_state_t enum (IDLE, READ, WAIT, SEND, DONE);
  - LANE_INDEX_WIDTH = $clog2(VECTOR_SIZE).
- One sub-module, vector_lane_buffer: loads the full word on a load signal and presents the lane selected by a lane-index input. The top level holds the FSM and counters.

## Test plan
- Single word: memory[0x10]=0x060504030201, start with base=0x10, count=1, byteReady=1 → bytes 01,02,03,04,05,06 on consecutive cycles t+3..t+8, done pulses at t+9, one memReadEnable only.
- Backpressure: same word, byteReady toggles 1,0,0,1,… → six bytes in order, byteData stable while stalled, no byte dropped or repeated.
- Wrap: base=0xFF, count=2 → memReadAddress 0xFF then 0x00, 12 bytes, one done pulse.
- Zero count: start with count=0 → no memReadEnable and no byteValid; done pulses at t+1.
- Start while busy: second start during SEND with base=0x40 → ignored, the original dump completes unchanged.
- Reset mid-operation: assert reset during SEND lane 3 → all outputs zero immediately; after release, a fresh start with count=1 produces a clean six-byte dump.
